fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the execute unit. Issues sequential
//  32-bit word reads to the instruction memory bus, buffers returned words with their
//  PC in a small FIFO and presents them to execute via valid/ready. Execute redirects
//  the fetch stream (jumps/branches/traps); redirects flush buffered and in-flight words.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
//  BUF_DEPTH  2              instruction FIFO entries; power of two, >= 2
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   asynchronous, active-low reset
//  redirect_valid  in   1   1-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   32  new fetch address
//  mem_req         out  1   read request, registered
//  mem_addr        out  32  read address, registered, held stable while mem_req && !mem_ack
//  mem_ack         in   1   request accepted, mem_rdata valid this cycle (same-cycle ack legal)
//  mem_rdata       in   32  read data
//  instr_valid     out  1   FIFO head valid (count != 0)
//  instr           out  32  FIFO head instruction word
//  instr_pc        out  32  FIFO head PC
//  instr_ready     in   1   execute consumes head when instr_valid && instr_ready
//  fetch_fault     out  1   misaligned redirect fault (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert): mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0,
//   instr_pc=0, fetch_fault=0, FIFO count=0, kill=0, state=IDLE.
//  States: IDLE, REQ, STALL, FAULT (FAULT only with macro).
//  IDLE: one cycle after reset release -> REQ with mem_addr=RESET_PC.
//  REQ: mem_req=1. On mem_ack: if kill, discard data, clear kill, mem_addr<=pending
//   redirect PC; else push {mem_addr, mem_rdata}, mem_addr<=mem_addr+4 (wraps mod 2^32).
//   After a push, if count reaches BUF_DEPTH (net of same-cycle pop) -> STALL, else stay
//   REQ; back-to-back requests allowed (mem_req stays 1, new address next cycle).
//  STALL: mem_req=0; -> REQ in the cycle after count < BUF_DEPTH. No push ever when full.
//  FIFO: push and pop in same cycle both take effect, count unchanged. instr/instr_pc
//   hold value when not popped; latency ack->instr_valid = 1 cycle.
//  Redirect (highest priority, overrides push and pop that cycle):
//   - FIFO flushed; instr_valid=0 next cycle.
//   - REQ without ack this cycle: mem_addr held until ack, kill=1, redirect_pc saved as
//     pending; after the killed ack the next request uses pending PC.
//   - REQ with ack this cycle: data discarded, next mem_addr=redirect_pc, kill=0.
//   - Redirect while kill=1: pending PC overwritten by newest redirect_pc.
//   - IDLE/STALL: -> REQ, mem_addr=redirect_pc next cycle.
//  Reset mid-request: in-flight request abandoned; memory must tolerate dropped req.
// CONFIGURATION
//  Macro FETCH_ALIGN_CHECK_EN.
//  Defined: redirect_pc[1:0]!=0 -> flush, state FAULT (after any in-flight ack is
//   killed), fetch_fault=1, mem_req=0, instr_valid=0; held until an aligned redirect,
//   which clears fetch_fault and resumes REQ at that address.
//  Undefined: redirect_pc[1:0] forced to 2'b00; fetch_fault tied 0; no FAULT state.
// TESTING
//  1 RESET_PC=0, ack every cycle, rdata=addr^32'hA5A5_0000, instr_ready=1 -> instr_pc
//    0,4,8,... consecutive, instr=32'hA5A5_0000,32'hA5A5_0004,...; no gaps after first.
//  2 instr_ready=0 from start -> exactly 2 acks then mem_req=0, head stays pc 0x0;
//    raise ready -> 0x0,0x4,0x8 delivered once each, no loss or duplicate.
//  3 ack delayed 3 cycles on addr 0x4, redirect_pc=0x100 during wait -> mem_addr holds
//    0x4 until ack, that word dropped, next mem_addr=0x100, next instr_pc=0x100.
//  4 redirect_pc=0x40 same cycle as ack and pop -> instr_valid=0 next cycle, next
//    mem_addr=0x40, first delivered instr_pc=0x40.
//  5 rst low asynchronously mid-REQ -> mem_req=0, instr_valid=0 before next clk edge;
//    after release fetch restarts at RESET_PC.
//  6 macro defined: redirect 0x102 -> fetch_fault=1, mem_req=0; redirect 0x200 ->
//    fault clears, fetch 0x200. Undefined: redirect 0x102 -> fetches 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch feeding execute through a small FIFO, with redirect/kill handling.
// Optional feature macro FETCH_ALIGN_CHECK_EN: misaligned redirects park the unit in FAULT until an aligned redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fetch_fault
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(BUF_DEPTH);
`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, REQ, STALL, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, STALL} state_t;
`endif
    state_t        state_q, state_d, go_rpc, go_pend;
    logic [31:0]   addr_q, addr_d, pend_q, pend_d, rpc;
    logic          kill_q, kill_d, req_q, fault_q, fault_d;
    logic [31:0]   ibuf_q [BUF_DEPTH];
    logic [31:0]   pbuf_q [BUF_DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ack, push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
    assign rpc     = redirect_pc;
    assign go_rpc  = (|redirect_pc[1:0]) ? FAULT : REQ;
    assign go_pend = (|pend_q[1:0]) ? FAULT : REQ;
    assign fault_d = (state_d == FAULT);
`else
    assign rpc     = redirect_pc & 32'hFFFF_FFFC;
    assign go_rpc  = REQ;
    assign go_pend = REQ;
    assign fault_d = 1'b0;
`endif

    assign ack   = (state_q == REQ) && mem_ack;
    assign push  = ack && !kill_q && !redirect_valid;
    assign pop   = (cnt_q != '0) && instr_ready && !redirect_valid;
    assign cnt_d = redirect_valid ? '0 : cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign instr_valid = (cnt_q != '0);
    assign instr       = ibuf_q[rd_q];
    assign instr_pc    = pbuf_q[rd_q];
    assign fetch_fault = fault_q;

    // next fetch state, address and kill bookkeeping; redirect outranks everything else
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        kill_d  = kill_q;
        pend_d  = pend_q;
        if (redirect_valid) begin
            if (state_q == REQ && !mem_ack) begin
                kill_d = 1'b1;
                pend_d = rpc;
            end else begin
                kill_d  = 1'b0;
                addr_d  = rpc;
                state_d = go_rpc;
            end
        end else if (state_q == IDLE) begin
            state_d = REQ;
        end else if (state_q == STALL) begin
            state_d = (cnt_q < FULL) ? REQ : STALL;
        end else if (ack && kill_q) begin
            kill_d  = 1'b0;
            addr_d  = pend_q;
            state_d = go_pend;
        end else if (ack) begin
            addr_d  = addr_q + 32'd4;
            state_d = (cnt_d == FULL) ? STALL : REQ;
        end
    end

    // state, request/address registers and the instruction FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= RESET_PC;
            pend_q  <= '0;
            kill_q  <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                ibuf_q[i] <= '0;
                pbuf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            kill_q  <= kill_d;
            req_q   <= (state_d == REQ);
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            if (redirect_valid) begin
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                if (push) begin
                    ibuf_q[wr_q] <= mem_rdata;
                    pbuf_q[wr_q] <= addr_q;
                    wr_q         <= wr_q + 1'b1;
                end
                if (pop) rd_q <= rd_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized stream checked against an expected-PC model.
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    logic        clk = 1'b0, rst = 1'b0;
    logic        redirect_valid = 1'b0, mem_ack = 1'b0, instr_ready = 1'b0;
    logic [31:0] redirect_pc = '0, mem_rdata = '0;
    logic        mem_req, instr_valid, fetch_fault;
    logic [31:0] mem_addr, instr, instr_pc;
    int          nchk = 0, nfail = 0;

    fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // memory answers the current request (if any) with data derived from its address
    task automatic drive(input bit en);
        mem_ack   = mem_req && en;
        mem_rdata = mem_addr ^ KEY;
    endtask

    task automatic do_reset;
        rst = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0; mem_ack = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        @(negedge clk);
        nchk++; if (mem_req !== 1'b0) begin nfail++; $display("FAIL reset_req got %0h exp 0", mem_req); end
        nchk++; if (mem_addr !== 32'h0) begin nfail++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
        nchk++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %0h exp 0", instr_valid); end
        nchk++; if (instr !== 32'h0) begin nfail++; $display("FAIL reset_instr got %h exp 0", instr); end
        nchk++; if (instr_pc !== 32'h0) begin nfail++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
        nchk++; if (fetch_fault !== 1'b0) begin nfail++; $display("FAIL reset_fault got %0h exp 0", fetch_fault); end
        rst = 1'b1;
        step;
        nchk++; if (mem_req !== 1'b1) begin nfail++; $display("FAIL reset_first_req got %0h exp 1", mem_req); end
    endtask

    task automatic test_stream;
        logic [31:0] e;
        do_reset;
        for (int i = 0; i < 12; i++) begin
            e = 32'(i * 4);
            instr_ready = 1'b1;
            drive(1'b1);
            step;
            nchk++; if (instr_valid !== 1'b1) begin nfail++; $display("FAIL stream_valid[%0d] got %0h exp 1", i, instr_valid); end
            nchk++; if (instr_pc !== e) begin nfail++; $display("FAIL stream_pc[%0d] got %h exp %h", i, instr_pc, e); end
            nchk++; if (instr !== (e ^ KEY)) begin nfail++; $display("FAIL stream_instr[%0d] got %h exp %h", i, instr, e ^ KEY); end
        end
    endtask

    task automatic test_backpressure;
        int acks;
        logic [31:0] got[$];
        do_reset;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1);
            if (mem_ack) acks++;
            step;
        end
        nchk++; if (acks != 2) begin nfail++; $display("FAIL bp_acks got %0d exp 2", acks); end
        nchk++; if (mem_req !== 1'b0) begin nfail++; $display("FAIL bp_req got %0h exp 0", mem_req); end
        nchk++; if (instr_valid !== 1'b1) begin nfail++; $display("FAIL bp_valid got %0h exp 1", instr_valid); end
        nchk++; if (instr_pc !== 32'h0) begin nfail++; $display("FAIL bp_head got %h exp 0", instr_pc); end
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1);
            if (instr_valid) got.push_back(instr_pc);
            step;
        end
        nchk++; if (got.size() < 3) begin nfail++; $display("FAIL bp_count got %0d exp >=3", got.size()); end
        foreach (got[k]) begin
            nchk++; if (got[k] !== 32'(k * 4)) begin nfail++; $display("FAIL bp_order[%0d] got %h exp %h", k, got[k], 32'(k * 4)); end
        end
    endtask

    task automatic test_kill;
        do_reset;
        instr_ready = 1'b1;
        drive(1'b1);
        step;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        drive(1'b0);
        step;
        redirect_valid = 1'b0;
        nchk++; if (mem_req !== 1'b1) begin nfail++; $display("FAIL kill_req got %0h exp 1", mem_req); end
        nchk++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL kill_flush got %0h exp 0", instr_valid); end
        for (int i = 0; i < 3; i++) begin
            nchk++; if (mem_addr !== 32'h4) begin nfail++; $display("FAIL kill_hold[%0d] got %h exp 4", i, mem_addr); end
            drive(i == 2);
            step;
        end
        nchk++; if (mem_addr !== 32'h100) begin nfail++; $display("FAIL kill_next_addr got %h exp 100", mem_addr); end
        nchk++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL kill_drop got %0h exp 0", instr_valid); end
        drive(1'b1);
        step;
        nchk++; if (instr_valid !== 1'b1) begin nfail++; $display("FAIL kill_valid got %0h exp 1", instr_valid); end
        nchk++; if (instr_pc !== 32'h100) begin nfail++; $display("FAIL kill_pc got %h exp 100", instr_pc); end
        nchk++; if (instr !== (32'h100 ^ KEY)) begin nfail++; $display("FAIL kill_instr got %h exp %h", instr, 32'h100 ^ KEY); end
    endtask

    task automatic test_redirect_ack;
        do_reset;
        instr_ready = 1'b1;
        drive(1'b1);
        step;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        drive(1'b1);
        step;
        redirect_valid = 1'b0;
        nchk++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL rack_flush got %0h exp 0", instr_valid); end
        nchk++; if (mem_addr !== 32'h40) begin nfail++; $display("FAIL rack_addr got %h exp 40", mem_addr); end
        nchk++; if (mem_req !== 1'b1) begin nfail++; $display("FAIL rack_req got %0h exp 1", mem_req); end
        drive(1'b1);
        step;
        nchk++; if (instr_valid !== 1'b1) begin nfail++; $display("FAIL rack_valid got %0h exp 1", instr_valid); end
        nchk++; if (instr_pc !== 32'h40) begin nfail++; $display("FAIL rack_pc got %h exp 40", instr_pc); end
    endtask

    task automatic test_async_reset;
        do_reset;
        instr_ready = 1'b0;
        drive(1'b1);
        step;
        #2 rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        nchk++; if (mem_req !== 1'b0) begin nfail++; $display("FAIL arst_req got %0h exp 0", mem_req); end
        nchk++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL arst_valid got %0h exp 0", instr_valid); end
        nchk++; if (mem_addr !== 32'h0) begin nfail++; $display("FAIL arst_addr got %h exp 0", mem_addr); end
        @(negedge clk);
        rst = 1'b1;
        step;
        nchk++; if (mem_req !== 1'b1) begin nfail++; $display("FAIL arst_restart_req got %0h exp 1", mem_req); end
        nchk++; if (mem_addr !== 32'h0) begin nfail++; $display("FAIL arst_restart_addr got %h exp 0", mem_addr); end
        drive(1'b1);
        step;
        nchk++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin nfail++; $display("FAIL arst_first got v=%0h pc=%h exp v=1 pc=0", instr_valid, instr_pc); end
    endtask

    task automatic test_align;
        do_reset;
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        drive(1'b1);
        step;
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            nchk++; if (fetch_fault !== 1'b1) begin nfail++; $display("FAIL align_fault[%0d] got %0h exp 1", i, fetch_fault); end
            nchk++; if (mem_req !== 1'b0) begin nfail++; $display("FAIL align_req[%0d] got %0h exp 0", i, mem_req); end
            nchk++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL align_valid[%0d] got %0h exp 0", i, instr_valid); end
            drive(1'b0);
            step;
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        drive(1'b0);
        step;
        redirect_valid = 1'b0;
        nchk++; if (fetch_fault !== 1'b0) begin nfail++; $display("FAIL align_clear got %0h exp 0", fetch_fault); end
        nchk++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin nfail++; $display("FAIL align_resume got req=%0h addr=%h exp 1/200", mem_req, mem_addr); end
        drive(1'b1);
        step;
        nchk++; if (instr_pc !== 32'h200) begin nfail++; $display("FAIL align_pc got %h exp 200", instr_pc); end
`else
        nchk++; if (fetch_fault !== 1'b0) begin nfail++; $display("FAIL align_fault got %0h exp 0", fetch_fault); end
        nchk++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin nfail++; $display("FAIL align_addr got req=%0h addr=%h exp 1/100", mem_req, mem_addr); end
        drive(1'b1);
        step;
        nchk++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin nfail++; $display("FAIL align_pc got v=%0h pc=%h exp 1/100", instr_valid, instr_pc); end
`endif
    endtask

    // random traffic: delivered stream must be consecutive words from the last redirect target
    task automatic test_random;
        logic [31:0] exp_pc, haddr, rp;
        bit hold, redir;
        int delivered;
        do_reset;
        exp_pc = 32'h0; hold = 1'b0; redir = 1'b0; delivered = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold) begin
                nchk++; if (mem_addr !== haddr) begin nfail++; $display("FAIL rand_hold[%0d] got %h exp %h", i, mem_addr, haddr); end
            end
            if (redir) begin
                nchk++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL rand_flush[%0d] got %0h exp 0", i, instr_valid); end
            end
            instr_ready    = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(15) == 0);
            rp = $urandom_range(32'h3ff);
`ifdef FETCH_ALIGN_CHECK_EN
            rp = rp & 32'hFFFF_FFFC;
`endif
            redirect_pc = rp;
            if (redirect_valid) exp_pc = rp & 32'hFFFF_FFFC;
            else if (instr_valid && instr_ready) begin
                nchk++; if (instr_pc !== exp_pc) begin nfail++; $display("FAIL rand_pc[%0d] got %h exp %h", i, instr_pc, exp_pc); end
                nchk++; if (instr !== (exp_pc ^ KEY)) begin nfail++; $display("FAIL rand_instr[%0d] got %h exp %h", i, instr, exp_pc ^ KEY); end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            drive($urandom_range(2) != 0);
            hold  = mem_req && !mem_ack;
            haddr = mem_addr;
            redir = redirect_valid;
            step;
        end
        redirect_valid = 1'b0;
        nchk++; if (delivered < 100) begin nfail++; $display("FAIL rand_progress got %0d exp >=100", delivered); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_kill;
        test_redirect_ack;
        test_async_reset;
        test_align;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
